// File: rtl/nurn_integrate_ctrl.sv
// Per-timestep neuron integration sequencer.
// Walks every neuron once per start pulse: fetches bias, membrane potential and
// threshold from the status memory, accumulates the weights of spiking axons,
// then writes back the saturated potential (or 0 on a spike).
// All outputs are registered; the next-cycle output values are computed
// alongside the next state so each strobe lines up with its FSM state.
module nurn_integrate_ctrl #(
  parameter int NUM_NURNS          = 256,
  parameter int NUM_AXONS          = 256,
  parameter int DSIZE              = 16,
  parameter int NURN_CNT_BIT_WIDTH = 8,
  parameter int AXON_CNT_BIT_WIDTH = 8
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         start_i,
  input  logic [NUM_AXONS-1:0]                         axonSpk_i,
  output logic                                         busy_o,
  output logic                                         done_o,
  output logic [NURN_CNT_BIT_WIDTH+1:0]                Addr_StatRd_A_o,
  output logic                                         rdEn_StatRd_A_o,
  input  logic [DSIZE-1:0]                             data_StatRd_A_i,
  output logic [NURN_CNT_BIT_WIDTH+1:0]                Addr_StatWr_B_o,
  output logic                                         wrEn_StatWr_B_o,
  output logic [DSIZE-1:0]                             data_StatWr_B_o,
  output logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] Addr_StatRd_E_o,
  output logic                                         rdEn_StatRd_E_o,
  input  logic [DSIZE-1:0]                             data_StatRd_E_i,
  output logic                                         spike_o,
  output logic [NURN_CNT_BIT_WIDTH-1:0]                spikeNurnId_o
);

  // Accumulator holds up to NUM_AXONS weights; the sum adds pot and bias on top.
  localparam int ACC_W = DSIZE + AXON_CNT_BIT_WIDTH;
  localparam int SUM_W = DSIZE + AXON_CNT_BIT_WIDTH + 2;

  localparam logic [NURN_CNT_BIT_WIDTH-1:0] LAST_NURN = NURN_CNT_BIT_WIDTH'(NUM_NURNS - 1);
  localparam logic [AXON_CNT_BIT_WIDTH-1:0] LAST_AXON = AXON_CNT_BIT_WIDTH'(NUM_AXONS - 1);

  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-DSIZE+1){1'b0}}, {(DSIZE-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-DSIZE+1){1'b1}}, {(DSIZE-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_BIAS = 3'd1,
    RD_POT  = 3'd2,
    RD_TH   = 3'd3,
    ACC     = 3'd4,
    DRAIN   = 3'd5,
    UPDATE  = 3'd6
  } state_t;

  // Clamp the wide sum into the signed DSIZE range.
  function automatic logic signed [DSIZE-1:0] satClamp(input logic signed [SUM_W-1:0] v);
    logic signed [DSIZE-1:0] r;
    if (v > SAT_MAX) begin
      r = SAT_MAX[DSIZE-1:0];
    end else if (v < SAT_MIN) begin
      r = SAT_MIN[DSIZE-1:0];
    end else begin
      r = v[DSIZE-1:0];
    end
    return r;
  endfunction

  state_t                          stateR, stateS;
  logic [NURN_CNT_BIT_WIDTH-1:0]   nurnR, nurnS;
  logic [AXON_CNT_BIT_WIDTH-1:0]   axonR, axonS, axonNextS;
  logic signed [ACC_W-1:0]         accR, accS, weightExtS, accNowS;
  logic signed [DSIZE-1:0]         biasR, biasS, potR, potS, thR, thS;
  logic [NUM_AXONS-1:0]            spkR, spkS;
  logic                            rdPendR;
  logic signed [SUM_W-1:0]         sumS;
  logic signed [DSIZE-1:0]         satS;
  logic                            fireS;

  logic                                         busyS, doneS, rdEnAS, wrEnBS, rdEnES, spikeS;
  logic [NURN_CNT_BIT_WIDTH+1:0]                addrAS, addrBS;
  logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] addrES;
  logic [DSIZE-1:0]                             dataBS;
  logic [NURN_CNT_BIT_WIDTH-1:0]                spikeIdS;

  // State, datapath and output registers; reset clears everything immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stateR          <= IDLE;
      nurnR           <= {NURN_CNT_BIT_WIDTH{1'b0}};
      axonR           <= {AXON_CNT_BIT_WIDTH{1'b0}};
      accR            <= {ACC_W{1'b0}};
      biasR           <= {DSIZE{1'b0}};
      potR            <= {DSIZE{1'b0}};
      thR             <= {DSIZE{1'b0}};
      spkR            <= {NUM_AXONS{1'b0}};
      rdPendR         <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      Addr_StatRd_A_o <= {(NURN_CNT_BIT_WIDTH+2){1'b0}};
      rdEn_StatRd_A_o <= 1'b0;
      Addr_StatWr_B_o <= {(NURN_CNT_BIT_WIDTH+2){1'b0}};
      wrEn_StatWr_B_o <= 1'b0;
      data_StatWr_B_o <= {DSIZE{1'b0}};
      Addr_StatRd_E_o <= {(NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH){1'b0}};
      rdEn_StatRd_E_o <= 1'b0;
      spike_o         <= 1'b0;
      spikeNurnId_o   <= {NURN_CNT_BIT_WIDTH{1'b0}};
    end else begin
      stateR          <= stateS;
      nurnR           <= nurnS;
      axonR           <= axonS;
      accR            <= accS;
      biasR           <= biasS;
      potR            <= potS;
      thR             <= thS;
      spkR            <= spkS;
      rdPendR         <= rdEn_StatRd_E_o;
      busy_o          <= busyS;
      done_o          <= doneS;
      Addr_StatRd_A_o <= addrAS;
      rdEn_StatRd_A_o <= rdEnAS;
      Addr_StatWr_B_o <= addrBS;
      wrEn_StatWr_B_o <= wrEnBS;
      data_StatWr_B_o <= dataBS;
      Addr_StatRd_E_o <= addrES;
      rdEn_StatRd_E_o <= rdEnES;
      spike_o         <= spikeS;
      spikeNurnId_o   <= spikeIdS;
    end
  end

  // Weight arriving this cycle (if a read was issued last cycle) and the resulting update value.
  always_comb begin
    weightExtS = {ACC_W{1'b0}};
    if (rdPendR) begin
      weightExtS = {{AXON_CNT_BIT_WIDTH{data_StatRd_E_i[DSIZE-1]}}, data_StatRd_E_i};
    end else begin
      weightExtS = {ACC_W{1'b0}};
    end
    accNowS = accR + weightExtS;
    sumS    = {{(SUM_W-DSIZE){potR[DSIZE-1]}}, potR}
            + {{(SUM_W-DSIZE){biasR[DSIZE-1]}}, biasR}
            + {{(SUM_W-ACC_W){accNowS[ACC_W-1]}}, accNowS};
    satS    = satClamp(sumS);
    fireS   = (satS >= thR);
  end

  // Next state plus the output values that belong to that next state.
  always_comb begin
    stateS    = stateR;
    nurnS     = nurnR;
    axonS     = axonR;
    accS      = accR;
    biasS     = biasR;
    potS      = potR;
    thS       = thR;
    spkS      = spkR;
    busyS     = busy_o;
    doneS     = 1'b0;
    rdEnAS    = 1'b0;
    addrAS    = {(NURN_CNT_BIT_WIDTH+2){1'b0}};
    wrEnBS    = 1'b0;
    addrBS    = {(NURN_CNT_BIT_WIDTH+2){1'b0}};
    dataBS    = {DSIZE{1'b0}};
    rdEnES    = 1'b0;
    addrES    = {(NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH){1'b0}};
    spikeS    = 1'b0;
    spikeIdS  = {NURN_CNT_BIT_WIDTH{1'b0}};
    axonNextS = axonR + {{(AXON_CNT_BIT_WIDTH-1){1'b0}}, 1'b1};

    case (stateR)
      IDLE: begin
        // A start coinciding with the done pulse is deliberately dropped.
        if (start_i && !done_o) begin
          stateS = RD_BIAS;
          spkS   = axonSpk_i;
          nurnS  = {NURN_CNT_BIT_WIDTH{1'b0}};
          busyS  = 1'b1;
          rdEnAS = 1'b1;
          addrAS = {{NURN_CNT_BIT_WIDTH{1'b0}}, 2'b00};
        end else begin
          busyS  = 1'b0;
        end
      end
      RD_BIAS: begin
        stateS = RD_POT;
        rdEnAS = 1'b1;
        addrAS = {nurnR, 2'b01};
      end
      RD_POT: begin
        biasS  = data_StatRd_A_i;
        stateS = RD_TH;
        rdEnAS = 1'b1;
        addrAS = {nurnR, 2'b10};
      end
      RD_TH: begin
        potS   = data_StatRd_A_i;
        stateS = ACC;
        axonS  = {AXON_CNT_BIT_WIDTH{1'b0}};
        accS   = {ACC_W{1'b0}};
        rdEnES = spkR[0];
        addrES = {nurnR, {AXON_CNT_BIT_WIDTH{1'b0}}};
      end
      ACC: begin
        if (axonR == {AXON_CNT_BIT_WIDTH{1'b0}}) begin
          thS = data_StatRd_A_i;
        end else begin
          thS = thR;
        end
        accS = accNowS;
        if (axonR == LAST_AXON) begin
          stateS = DRAIN;
        end else begin
          axonS  = axonNextS;
          rdEnES = spkR[axonNextS];
          addrES = {nurnR, axonNextS};
        end
      end
      DRAIN: begin
        // The write-back strobe is prepared here so it appears during UPDATE.
        accS   = accNowS;
        stateS = UPDATE;
        wrEnBS = 1'b1;
        addrBS = {nurnR, 2'b01};
        if (fireS) begin
          dataBS   = {DSIZE{1'b0}};
          spikeS   = 1'b1;
          spikeIdS = nurnR;
        end else begin
          dataBS   = satS;
        end
      end
      UPDATE: begin
        if (nurnR == LAST_NURN) begin
          stateS = IDLE;
          doneS  = 1'b1;
          busyS  = 1'b0;
        end else begin
          nurnS  = nurnR + {{(NURN_CNT_BIT_WIDTH-1){1'b0}}, 1'b1};
          stateS = RD_BIAS;
          rdEnAS = 1'b1;
          addrAS = {nurnR + {{(NURN_CNT_BIT_WIDTH-1){1'b0}}, 1'b1}, 2'b00};
        end
      end
      default: begin
        stateS = IDLE;
        busyS  = 1'b0;
      end
    endcase
  end

endmodule
